ctrl_tile_sched: RTL

CTRL_TILE_SCHED -- requirements
Module: ctrl_tile_sched

---
 rtl/ctrl_tile_sched.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ctrl_tile_sched.sv
// ctrl_tile_sched: layer-level scheduler for a three-stage tile pipeline
// (load -> execute -> write-back) sharing two ping-pong buffer pairs.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle layer start request (accepted only when idle)
//   num_tiles               tiles in the layer, latched on accepted start
//   bs/bp_bw_out_times_cfg  write-back tile sizes, latched on accepted start
//   bs/bp_bw_out_times      registered sizes, loaded at the first wb start of a layer
//   ld/ex/wb_tile_start     one-cycle stage start pulses
//   ld/ex/wb_tile_end       one-cycle stage completion pulses
//   ld/ex/wb_buf_sel        ping-pong slot of the stage's current tile
//   busy                    layer in progress
//   done                    one-cycle layer completion pulse
module ctrl_tile_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tiles,
  input  logic [15:0]      bs_bw_out_times_cfg,
  input  logic [15:0]      bp_bw_out_times_cfg,
  output logic [15:0]      bs_bw_out_times,
  output logic [15:0]      bp_bw_out_times,
  output logic             ld_tile_start,
  output logic             ex_tile_start,
  output logic             wb_tile_start,
  input  logic             ld_tile_end,
  input  logic             ex_tile_end,
  input  logic             wb_tile_end,
  output logic             ld_buf_sel,
  output logic             ex_buf_sel,
  output logic             wb_buf_sel,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           state;
  logic [CNT_W-1:0] n_tiles;
  logic [15:0]      bs_cfg;
  logic [15:0]      bp_cfg;
  logic [CNT_W-1:0] ld_iss;
  logic [CNT_W-1:0] ld_done;
  logic [CNT_W-1:0] ex_iss;
  logic [CNT_W-1:0] ex_done;
  logic [CNT_W-1:0] wb_iss;
  logic [CNT_W-1:0] wb_done;
  logic             ld_active;
  logic             ex_active;
  logic             wb_active;

  logic             ld_issue;
  logic             ex_issue;
  logic             wb_issue;
  logic             ld_fin;
  logic             ex_fin;
  logic             wb_fin;
  logic             last_wb;

  // Issue decisions use only registered state. The "< 2" terms bound how many
  // tiles a producer may run ahead of its consumer: one per ping-pong slot.
  always_comb begin
    ld_issue = (state == RUN) && !ld_active && (ld_iss < n_tiles)
               && ((ld_iss - ex_done) < TWO);
    ex_issue = (state == RUN) && !ex_active && (ex_iss < ld_done)
               && ((ex_iss - wb_done) < TWO);
    wb_issue = (state == RUN) && !wb_active && (wb_iss < ex_done);
    ld_fin   = ld_active && ld_tile_end;
    ex_fin   = ex_active && ex_tile_end;
    wb_fin   = wb_active && wb_tile_end;
    last_wb  = wb_fin && ((wb_done + ONE) == n_tiles);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      n_tiles         <= '0;
      bs_cfg          <= '0;
      bp_cfg          <= '0;
      ld_iss          <= '0;
      ld_done         <= '0;
      ex_iss          <= '0;
      ex_done         <= '0;
      wb_iss          <= '0;
      wb_done         <= '0;
      ld_active       <= 1'b0;
      ex_active       <= 1'b0;
      wb_active       <= 1'b0;
      ld_buf_sel      <= 1'b0;
      ex_buf_sel      <= 1'b0;
      wb_buf_sel      <= 1'b0;
      ld_tile_start   <= 1'b0;
      ex_tile_start   <= 1'b0;
      wb_tile_start   <= 1'b0;
      bs_bw_out_times <= '0;
      bp_bw_out_times <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      ld_tile_start <= 1'b0;
      ex_tile_start <= 1'b0;
      wb_tile_start <= 1'b0;
      done          <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            n_tiles    <= num_tiles;
            bs_cfg     <= bs_bw_out_times_cfg;
            bp_cfg     <= bp_bw_out_times_cfg;
            ld_iss     <= '0;
            ld_done    <= '0;
            ex_iss     <= '0;
            ex_done    <= '0;
            wb_iss     <= '0;
            wb_done    <= '0;
            ld_active  <= 1'b0;
            ex_active  <= 1'b0;
            wb_active  <= 1'b0;
            ld_buf_sel <= 1'b0;
            ex_buf_sel <= 1'b0;
            wb_buf_sel <= 1'b0;
            // An empty layer completes straight from idle so that done lands
            // one cycle after start with busy never raised.
            if (num_tiles == '0) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end

        RUN: begin
          // Issue needs !active and end needs active, so per stage at most
          // one of the two branches fires on any edge.
          if (ld_issue) begin
            ld_tile_start <= 1'b1;
            ld_active     <= 1'b1;
            ld_iss        <= ld_iss + ONE;
          end else if (ld_fin) begin
            ld_active  <= 1'b0;
            ld_done    <= ld_done + ONE;
            ld_buf_sel <= ~ld_buf_sel;
          end

          if (ex_issue) begin
            ex_tile_start <= 1'b1;
            ex_active     <= 1'b1;
            ex_iss        <= ex_iss + ONE;
          end else if (ex_fin) begin
            ex_active  <= 1'b0;
            ex_done    <= ex_done + ONE;
            ex_buf_sel <= ~ex_buf_sel;
          end

          if (wb_issue) begin
            wb_tile_start <= 1'b1;
            wb_active     <= 1'b1;
            wb_iss        <= wb_iss + ONE;
            if (wb_iss == '0) begin
              bs_bw_out_times <= bs_cfg;
              bp_bw_out_times <= bp_cfg;
            end
          end else if (wb_fin) begin
            wb_active  <= 1'b0;
            wb_done    <= wb_done + ONE;
            wb_buf_sel <= ~wb_buf_sel;
          end

          if (last_wb) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
